// File: rtl/tl_fragmenter_ul_pkg.sv
`default_nettype none
// ============================================================================
// tl_fragmenter_ul_pkg : shared TileLink-UL opcodes, fragmenter state type and helpers
// Revision: 1.0
// ============================================================================
package tl_fragmenter_ul_pkg;

    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GET  = 2'd1,
        ST_PUT  = 2'd2
    } frag_state_e;

    // Number of beat-sized fragments a request of 2^size bytes occupies.
    function automatic int unsigned frag_count(input int unsigned size, input int unsigned frag_lg);
        return (size > frag_lg) ? (32'd1 << (size - frag_lg)) : 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_fragmenter_ul_if.sv
`default_nettype none
// ============================================================================
// tl_fragmenter_ul_if : TileLink-UL A/D channel bundle with master/slave views
// Revision: 1.0
// ============================================================================
interface tl_fragmenter_ul_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 28,
    parameter int SRC_W  = 5,
    parameter int SIZE_W = 3
);
    logic                a_ready;
    logic                a_valid;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [SIZE_W-1:0]   a_size;
    logic [SRC_W-1:0]    a_source;
    logic [ADDR_W-1:0]   a_address;
    logic [DATA_W/8-1:0] a_mask;
    logic [DATA_W-1:0]   a_data;
    logic                a_corrupt;

    logic                d_ready;
    logic                d_valid;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [SIZE_W-1:0]   d_size;
    logic [SRC_W-1:0]    d_source;
    logic                d_sink;
    logic                d_denied;
    logic [DATA_W-1:0]   d_data;
    logic                d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface
`default_nettype wire

// File: rtl/tl_fragmenter_ul_tracker.sv
`default_nettype none
// ============================================================================
// tl_fragmenter_ul_tracker : per-source request size table and sticky denied accumulator
// Revision: 1.0
// ============================================================================
module tl_fragmenter_ul_tracker
    import tl_fragmenter_ul_pkg::*;
#(
    parameter int SRC_W  = 5,
    parameter int SIZE_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SRC_W-1:0]  wr_src,
    input  logic [SIZE_W-1:0] wr_size,
    input  logic [SRC_W-1:0]  rd_src,
    output logic [SIZE_W-1:0] rd_size,
    output logic              rd_deny,
    input  logic              acc_set,
    input  logic              acc_clr
);
    localparam int ENTRIES = 1 << SRC_W;

    logic [SIZE_W-1:0]  size_tab [ENTRIES];
    logic [ENTRIES-1:0] deny_acc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                size_tab[i] <= '0;
            end
            deny_acc <= '0;
        end else begin
            if (wr_en) begin
                size_tab[wr_src] <= wr_size;
            end
            if (acc_clr) begin
                deny_acc[rd_src] <= 1'b0;
            end else if (acc_set) begin
                deny_acc[rd_src] <= 1'b1;
            end
        end
    end

    // Bypass covers a slave that answers in the same cycle the request is issued.
    assign rd_size = (wr_en && (wr_src == rd_src)) ? wr_size : size_tab[rd_src];
    assign rd_deny = deny_acc[rd_src];

endmodule
`default_nettype wire

// File: rtl/tl_fragmenter_ul.sv
`default_nettype none
// ============================================================================
// tl_fragmenter_ul : splits multi-beat TL-UL requests into beat-sized ones, merges acks
// Revision: 1.0
// ============================================================================
module tl_fragmenter_ul
    import tl_fragmenter_ul_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 28,
    parameter int SRC_W  = 5,
    parameter int SIZE_W = 3,
    parameter int MAX_LG = 6
) (
    input  logic               clock,
    input  logic               reset,
    tl_fragmenter_ul_if.slave  tl_in,
    tl_fragmenter_ul_if.master tl_out
);
    localparam int BYTES   = DATA_W / 8;
    localparam int FRAG_LG = $clog2(BYTES);
    localparam int CNT_W   = MAX_LG - FRAG_LG;

    frag_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  last_idx;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] offset;
    logic              is_get;
    logic              is_put;
    logic              multi;
    logic              first;
    logic              a_fire;

    logic [SRC_W-1:0]  d_src;
    logic [CNT_W-1:0]  d_idx;
    logic              is_ack;
    logic              absorb;
    logic              d_fire;
    logic [SIZE_W-1:0] rd_size;
    logic              rd_deny;

    always_comb begin
        is_get   = (tl_in.a_opcode == OP_GET);
        is_put   = (tl_in.a_opcode == OP_PUT_FULL) || (tl_in.a_opcode == OP_PUT_PARTIAL);
        multi    = (is_get || is_put) && (32'(tl_in.a_size) > FRAG_LG);
        last_idx = multi ? CNT_W'(frag_count(32'(tl_in.a_size), FRAG_LG) - 32'd1) : '0;
        first    = (state == ST_IDLE);
        idx      = first ? last_idx : cnt;
        // Fragment k = last_idx - idx, since indices count down toward the final beat.
        offset   = ADDR_W'(last_idx - idx) << FRAG_LG;

        tl_out.a_valid   = reset && tl_in.a_valid;
        tl_out.a_opcode  = tl_in.a_opcode;
        tl_out.a_param   = tl_in.a_param;
        tl_out.a_size    = (32'(tl_in.a_size) > FRAG_LG) ? 2'(FRAG_LG) : tl_in.a_size[1:0];
        tl_out.a_source  = {tl_in.a_source, idx};
        tl_out.a_address = tl_in.a_address + offset;
        tl_out.a_mask    = (is_get && multi) ? '1 : tl_in.a_mask;
        tl_out.a_data    = tl_in.a_data;
        tl_out.a_corrupt = tl_in.a_corrupt;

        a_fire         = tl_out.a_valid && tl_out.a_ready;
        tl_in.a_ready  = reset && tl_out.a_ready && !(is_get && (idx != '0));
    end

    always_comb begin
        d_src  = tl_out.d_source[SRC_W+CNT_W-1 -: SRC_W];
        d_idx  = tl_out.d_source[CNT_W-1:0];
        is_ack = (tl_out.d_opcode == OP_ACCESS_ACK);
        absorb = is_ack && (d_idx != '0);

        tl_in.d_valid   = reset && tl_out.d_valid && !absorb;
        tl_out.d_ready  = reset && (absorb || tl_in.d_ready);
        d_fire          = tl_out.d_valid && tl_out.d_ready;

        tl_in.d_opcode  = tl_out.d_opcode;
        tl_in.d_param   = tl_out.d_param;
        tl_in.d_size    = rd_size;
        tl_in.d_source  = d_src;
        tl_in.d_sink    = tl_out.d_sink;
        tl_in.d_denied  = tl_out.d_denied || (is_ack && rd_deny);
        tl_in.d_data    = tl_out.d_data;
        tl_in.d_corrupt = tl_out.d_corrupt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            if (tl_in.a_valid) begin
                assert (32'(tl_in.a_size) <= MAX_LG);
            end
            if (a_fire && (is_get || is_put)) begin
                if (idx == '0) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= is_get ? ST_GET : ST_PUT;
                    cnt   <= idx - CNT_W'(1);
                end
            end
        end
    end

    tl_fragmenter_ul_tracker #(
        .SRC_W  (SRC_W),
        .SIZE_W (SIZE_W)
    ) u_tracker (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (a_fire && first),
        .wr_src  (tl_in.a_source),
        .wr_size (tl_in.a_size),
        .rd_src  (d_src),
        .rd_size (rd_size),
        .rd_deny (rd_deny),
        .acc_set (d_fire && absorb && tl_out.d_denied),
        .acc_clr (d_fire && is_ack && (d_idx == '0))
    );

endmodule
`default_nettype wire
